// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master byte controller.
// quarter_lines() gives the open-drain enables to apply at the start of each bit quarter.
package i2c_pkg;

  localparam int unsigned I2C_DATA_WIDTH = 8;
  localparam int unsigned I2C_BIT_CNT_W  = 4;

  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_STOP  = 2'd1,
    CMD_WRITE = 2'd2,
    CMD_READ  = 2'd3
  } i2c_cmd_t;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StStop,
    StWbit,
    StRbit,
    StWack,
    StRack,
    StDone
  } i2c_mstr_state_t;

  // Returns {scl_oe, sda_oe}; lines not touched in a quarter keep their current value.
  function automatic logic [1:0] quarter_lines(input i2c_mstr_state_t st, input logic [1:0] q,
                                               input logic bit_oe, input logic [1:0] cur);
    logic scl;
    logic sda;
    scl = cur[1];
    sda = cur[0];
    case (st)
      StStart: begin
        case (q)
          2'd0:    sda = 1'b0;
          2'd1:    scl = 1'b0;
          2'd2:    sda = 1'b1;
          default: scl = 1'b1;
        endcase
      end
      StStop: begin
        case (q)
          2'd0:    sda = 1'b1;
          2'd1:    scl = 1'b0;
          2'd2:    sda = 1'b0;
          default: ;
        endcase
      end
      StWbit, StRbit, StWack, StRack: begin
        case (q)
          2'd0: begin
            scl = 1'b1;
            sda = bit_oe;
          end
          2'd1:    scl = 1'b0;
          2'd3:    scl = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
    return {scl, sda};
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Prescaler producing a one-cycle qtick every CLK_DIV enabled clocks.
// The count restarts from zero whenever the enable drops.
module i2c_quarter_tick #(
  parameter int unsigned CLK_DIV = 100
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic qtick_o
);

  localparam int unsigned   CntW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      r_cnt <= '0;
    end else if (r_cnt == CntMax) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign qtick_o = en_i && (r_cnt == CntMax);

endmodule

// File: rtl/i2c_master_byte_ctrl.sv
// Single-master I2C byte controller: START / STOP / WRITE / READ one command at a time,
// driving SCL/SDA as registered open-drain pull-low enables.
module i2c_master_byte_ctrl
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 100
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  i2c_cmd_t                  cmd_i,
  input  logic [I2C_DATA_WIDTH-1:0] wdata_i,
  input  logic                      rd_ack_i,
  output logic                      done_o,
  output logic [I2C_DATA_WIDTH-1:0] rdata_o,
  output logic                      ack_o,
  output logic                      err_o,
  output logic                      busy_o,
  output logic                      scl_oe_o,
  output logic                      sda_oe_o,
  input  logic                      sda_i
);

  localparam logic [I2C_BIT_CNT_W-1:0] LastBit = I2C_BIT_CNT_W'(I2C_DATA_WIDTH - 1);

  i2c_mstr_state_t           r_state, w_state_d;
  logic [1:0]                r_quarter, w_quarter_d;
  logic [I2C_BIT_CNT_W-1:0]  r_bit, w_bit_d;
  logic [I2C_DATA_WIDTH-1:0] r_shift, w_shift_d;
  logic [I2C_DATA_WIDTH-1:0] r_rdata, w_rdata_d;
  logic                      r_rd_ack, w_rd_ack_d;
  logic                      r_ack, w_ack_d;
  logic                      r_err, w_err_d;
  logic                      r_busy, w_busy_d;
  logic                      r_scl_oe, r_sda_oe;
  logic [1:0]                w_lines_d;
  logic                      w_qstart, w_tick_en, w_qtick, w_bit_oe;

  assign w_tick_en = (r_state != StIdle) && (r_state != StDone);

  i2c_quarter_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_quarter_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (w_tick_en),
    .qtick_o(w_qtick)
  );

  always_comb begin
    w_state_d   = r_state;
    w_quarter_d = r_quarter;
    w_bit_d     = r_bit;
    w_shift_d   = r_shift;
    w_rdata_d   = r_rdata;
    w_rd_ack_d  = r_rd_ack;
    w_ack_d     = r_ack;
    w_err_d     = r_err;
    w_busy_d    = r_busy;
    w_qstart    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (cmd_valid_i) begin
          w_rd_ack_d  = rd_ack_i;
          w_shift_d   = wdata_i;
          w_quarter_d = 2'd0;
          w_bit_d     = '0;
          w_err_d     = 1'b0;
          // Anything but START needs the bus: complete at once with an error, no line activity.
          if ((cmd_i != CMD_START) && !r_busy) begin
            w_state_d = StDone;
            w_err_d   = 1'b1;
          end else begin
            w_qstart = 1'b1;
            unique case (cmd_i)
              CMD_START: w_state_d = StStart;
              CMD_STOP:  w_state_d = StStop;
              CMD_WRITE: w_state_d = StWbit;
              CMD_READ:  w_state_d = StRbit;
            endcase
          end
        end
      end
      StDone: w_state_d = StIdle;
      default: begin
        if (w_qtick) begin
          if (r_quarter == 2'd2) begin
            if (r_state == StRbit) w_shift_d = {r_shift[I2C_DATA_WIDTH-2:0], sda_i};
            if (r_state == StWack) w_ack_d = ~sda_i;
          end
          if (r_quarter != 2'd3) begin
            w_quarter_d = r_quarter + 2'd1;
            w_qstart    = 1'b1;
          end else begin
            w_quarter_d = 2'd0;
            unique case (r_state)
              StStart: begin
                w_state_d = StDone;
                w_busy_d  = 1'b1;
              end
              StStop: begin
                w_state_d = StDone;
                w_busy_d  = 1'b0;
              end
              StWbit: begin
                w_shift_d = r_shift << 1;
                w_qstart  = 1'b1;
                if (r_bit == LastBit) begin
                  w_state_d = StWack;
                  w_bit_d   = '0;
                end else begin
                  w_bit_d = r_bit + I2C_BIT_CNT_W'(1);
                end
              end
              StRbit: begin
                w_qstart = 1'b1;
                if (r_bit == LastBit) begin
                  w_state_d = StRack;
                  w_bit_d   = '0;
                end else begin
                  w_bit_d = r_bit + I2C_BIT_CNT_W'(1);
                end
              end
              StWack: w_state_d = StDone;
              StRack: begin
                w_state_d = StDone;
                w_rdata_d = r_shift;
              end
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  // SDA value for q0 of the bit being entered, derived from next-state values.
  always_comb begin
    case (w_state_d)
      StWbit:  w_bit_oe = ~w_shift_d[I2C_DATA_WIDTH-1];
      StRack:  w_bit_oe = w_rd_ack_d;
      default: w_bit_oe = 1'b0;
    endcase
    w_lines_d = w_qstart ? quarter_lines(w_state_d, w_quarter_d, w_bit_oe, {r_scl_oe, r_sda_oe})
                         : {r_scl_oe, r_sda_oe};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= StIdle;
      r_quarter <= 2'd0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_rdata   <= '0;
      r_rd_ack  <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_scl_oe  <= 1'b0;
      r_sda_oe  <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_quarter <= w_quarter_d;
      r_bit     <= w_bit_d;
      r_shift   <= w_shift_d;
      r_rdata   <= w_rdata_d;
      r_rd_ack  <= w_rd_ack_d;
      r_ack     <= w_ack_d;
      r_err     <= w_err_d;
      r_busy    <= w_busy_d;
      r_scl_oe  <= w_lines_d[1];
      r_sda_oe  <= w_lines_d[0];
    end
  end

  assign cmd_ready_o = (r_state == StIdle);
  assign done_o      = (r_state == StDone);
  assign rdata_o     = r_rdata;
  assign ack_o       = r_ack;
  assign err_o       = r_err;
  assign busy_o      = r_busy;
  assign scl_oe_o    = r_scl_oe;
  assign sda_oe_o    = r_sda_oe;

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Bench for i2c_master_byte_ctrl: open-drain bus with a behavioural slave at address 0x22
// and a transaction-level model of expected latency, ACK, read data and bus ownership.
`timescale 1ns/1ps
module tb_i2c_master_byte_ctrl;
  import i2c_pkg::*;

  localparam int unsigned CD         = 4;
  localparam logic [6:0]  SLAVE_ADDR = 7'h22;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  i2c_cmd_t   cmd;
  logic [7:0] wdata;
  logic       rd_ack;
  logic       cmd_ready, done, ack, err, busy, scl_oe, sda_oe;
  logic [7:0] rdata;
  logic       s_sda_oe;
  logic       scl_bus, sda_bus;

  assign scl_bus = ~scl_oe;
  assign sda_bus = ~(sda_oe | s_sda_oe);

  i2c_master_byte_ctrl #(
    .CLK_DIV(CD)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_i      (cmd),
    .wdata_i    (wdata),
    .rd_ack_i   (rd_ack),
    .done_o     (done),
    .rdata_o    (rdata),
    .ack_o      (ack),
    .err_o      (err),
    .busy_o     (busy),
    .scl_oe_o   (scl_oe),
    .sda_oe_o   (sda_oe),
    .sda_i      (sda_bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural slave: samples the bus away from the DUT clock edge.
  logic [7:0] s_tx_q[$];
  logic [7:0] s_rx_q[$];
  logic       p_scl = 1'b1, p_sda = 1'b1;
  int         s_cnt = 0;
  int         starts_seen = 0;
  logic       s_active = 1'b0, s_addr_ph = 1'b0, s_addressed = 1'b0, s_read = 1'b0;
  logic       s_tx = 1'b0, s_last_mack = 1'b0;
  logic [7:0] s_sh = 8'h00, s_byte = 8'hFF;

  initial s_sda_oe = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      s_active = 1'b0;
      s_tx     = 1'b0;
      s_sda_oe = 1'b0;
    end else if (p_scl && scl_bus && p_sda && !sda_bus) begin
      s_active    = 1'b1;
      s_cnt       = 0;
      s_addr_ph   = 1'b1;
      s_addressed = 1'b0;
      s_tx        = 1'b0;
      s_sda_oe    = 1'b0;
      starts_seen++;
    end else if (p_scl && scl_bus && !p_sda && sda_bus) begin
      s_active = 1'b0;
      s_tx     = 1'b0;
      s_sda_oe = 1'b0;
    end else if (s_active && !p_scl && scl_bus) begin
      if (s_cnt < 8) s_sh = {s_sh[6:0], sda_bus};
      else if (s_tx) s_last_mack = ~sda_bus;
      s_cnt++;
    end else if (s_active && p_scl && !scl_bus) begin
      if (s_cnt == 8) begin
        if (s_tx) begin
          s_sda_oe = 1'b0;
        end else if (s_addr_ph) begin
          s_addressed = (s_sh[7:1] == SLAVE_ADDR);
          s_read      = s_sh[0];
          s_sda_oe    = s_addressed;
        end else if (s_addressed && !s_read) begin
          s_rx_q.push_back(s_sh);
          s_sda_oe = 1'b1;
        end
      end else if (s_cnt == 9) begin
        s_cnt    = 0;
        s_sda_oe = 1'b0;
        if (s_addressed && s_read && (s_addr_ph || s_last_mack)) begin
          s_tx     = 1'b1;
          s_byte   = (s_tx_q.size() > 0) ? s_tx_q.pop_front() : 8'hFF;
          s_sda_oe = ~s_byte[7];
        end else begin
          s_tx = 1'b0;
        end
        s_addr_ph = 1'b0;
      end else if (s_tx) begin
        s_sda_oe = ~s_byte[3'(7 - s_cnt)];
      end
    end
    p_scl = scl_bus;
    p_sda = sda_bus;
  end

  // Every SCL high pulse while the bus is owned must last two quarters.
  int   hi_len = 0;
  logic hi_ok  = 1'b0;
  logic any_oe = 1'b0;

  always @(negedge clk) begin
    if (scl_bus) begin
      hi_len++;
      if (!busy) hi_ok = 1'b0;
    end else begin
      if (hi_len > 0 && hi_ok) check("scl_high_len", hi_len, 2 * CD);
      hi_len = 0;
      hi_ok  = 1'b1;
    end
    if (scl_oe || sda_oe) any_oe = 1'b1;
  end

  // Transaction-level reference model.
  logic       m_owned = 1'b0, m_addr_ph = 1'b0, m_addressed = 1'b0, m_read = 1'b0;
  logic       m_ack = 1'b0;
  logic [7:0] m_rdata = 8'h00;
  logic [7:0] m_tx_q[$];
  logic [7:0] m_rx_q[$];

  task automatic push_tx(input logic [7:0] b);
    s_tx_q.push_back(b);
    m_tx_q.push_back(b);
  endtask

  task automatic issue(input i2c_cmd_t c, input logic [7:0] d, input logic ra);
    int   lat;
    int   exp_lat;
    logic legal;
    logic slave_tx;
    legal    = (c == CMD_START) || m_owned;
    exp_lat  = !legal ? 1 : ((c == CMD_WRITE) || (c == CMD_READ)) ? 36 * CD + 1 : 4 * CD + 1;
    slave_tx = m_addressed && m_read;
    @(negedge clk);
    check("ready_before", cmd_ready, 1'b1);
    cmd       = c;
    wdata     = d;
    rd_ack    = ra;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    wdata     = 8'($urandom);
    rd_ack    = 1'($urandom);
    if (exp_lat > 1) check("ready_low", cmd_ready, 1'b0);
    lat = 1;
    while (!done && lat < 40 * CD + 10) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, exp_lat);
    check("err", err, !legal);
    if (legal) begin
      case (c)
        CMD_START: begin
          m_owned     = 1'b1;
          m_addr_ph   = 1'b1;
          m_addressed = 1'b0;
        end
        CMD_STOP: begin
          m_owned     = 1'b0;
          m_addressed = 1'b0;
        end
        CMD_WRITE: begin
          if (m_addr_ph) begin
            m_ack       = (d[7:1] == SLAVE_ADDR);
            m_addressed = m_ack;
            m_read      = d[0];
            m_addr_ph   = 1'b0;
          end else begin
            m_ack = m_addressed && !m_read;
            if (m_ack) m_rx_q.push_back(d);
          end
        end
        CMD_READ: begin
          m_rdata = (slave_tx && m_tx_q.size() > 0) ? m_tx_q.pop_front() : 8'hFF;
          if (slave_tx) check("master_ack_bit", s_last_mack, ra);
          if (!ra) m_addressed = 1'b0;
        end
      endcase
    end
    check("ack", ack, m_ack);
    check("rdata", rdata, m_rdata);
    check("busy", busy, m_owned);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         st0;
    int         seen;
    logic [7:0] b;
    logic [6:0] a;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd       = CMD_START;
    wdata     = 8'h00;
    rd_ack    = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_ack", ack, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_scl_oe", scl_oe, 1'b0);
    check("rst_sda_oe", sda_oe, 1'b0);

    // Bus not owned: WRITE completes at once with err, no line activity.
    any_oe = 1'b0;
    issue(CMD_WRITE, 8'h12, 1'b0);
    check("illegal_no_lines", any_oe, 1'b0);

    // Addressed write: two fixed bytes then a random one.
    issue(CMD_START, 8'h00, 1'b0);
    issue(CMD_WRITE, 8'h44, 1'b0);
    issue(CMD_WRITE, 8'hA5, 1'b0);
    issue(CMD_WRITE, 8'($urandom), 1'b0);
    issue(CMD_STOP, 8'h00, 1'b0);

    // Reads: fixed pair, then a random-length random run ending in NACK.
    push_tx(8'h3C);
    push_tx(8'hC3);
    issue(CMD_START, 8'h00, 1'b0);
    issue(CMD_WRITE, 8'h45, 1'b0);
    issue(CMD_READ, 8'h00, 1'b1);
    issue(CMD_READ, 8'h00, 1'b0);
    issue(CMD_STOP, 8'h00, 1'b0);
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) push_tx(8'($urandom));
    issue(CMD_START, 8'h00, 1'b0);
    issue(CMD_WRITE, 8'h45, 1'b0);
    for (int i = 0; i < n; i++) issue(CMD_READ, 8'h00, (i != n - 1));
    issue(CMD_STOP, 8'h00, 1'b0);

    // No responder, then STOP without ownership.
    issue(CMD_START, 8'h00, 1'b0);
    issue(CMD_WRITE, 8'hA0, 1'b0);
    issue(CMD_STOP, 8'h00, 1'b0);
    issue(CMD_STOP, 8'h00, 1'b0);
    a = 7'($urandom);
    if (a == SLAVE_ADDR) a = ~a;
    issue(CMD_START, 8'h00, 1'b0);
    issue(CMD_WRITE, {a, 1'b0}, 1'b0);
    issue(CMD_READ, 8'h00, 1'b0);
    issue(CMD_STOP, 8'h00, 1'b0);

    // Repeated start.
    push_tx(8'($urandom));
    st0 = starts_seen;
    issue(CMD_START, 8'h00, 1'b0);
    issue(CMD_WRITE, 8'h44, 1'b0);
    b = 8'($urandom);
    issue(CMD_WRITE, b, 1'b0);
    issue(CMD_START, 8'h00, 1'b0);
    issue(CMD_WRITE, 8'h45, 1'b0);
    issue(CMD_READ, 8'h00, 1'b0);
    issue(CMD_STOP, 8'h00, 1'b0);
    check("starts_seen", starts_seen - st0, 2);

    // Reset in the middle of bit 4 of a WRITE.
    issue(CMD_START, 8'h00, 1'b0);
    @(negedge clk);
    cmd       = CMD_WRITE;
    wdata     = 8'h44;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4 * 4 * CD + CD) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_scl_oe", scl_oe, 1'b0);
    check("midrst_sda_oe", sda_oe, 1'b0);
    check("midrst_ready", cmd_ready, 1'b1);
    check("midrst_done", done, 1'b0);
    rst         = 1'b0;
    m_owned     = 1'b0;
    m_addressed = 1'b0;
    m_ack       = 1'b0;
    m_rdata     = 8'h00;
    seen        = 0;
    repeat (40 * CD) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("no_done_after_rst", seen, 0);
    issue(CMD_START, 8'h00, 1'b0);
    issue(CMD_WRITE, 8'h44, 1'b0);
    issue(CMD_STOP, 8'h00, 1'b0);

    check("rx_count", s_rx_q.size(), m_rx_q.size());
    for (int i = 0; i < m_rx_q.size() && i < s_rx_q.size(); i++) begin
      check("rx_byte", s_rx_q[i], m_rx_q[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
